// File: rtl/blinker_tick_monitor_if.sv
// ----------------------------------------------------------------------------
// blinker_tick_monitor_if
//   Bundles the tick input and the status outputs of the blinker tick monitor.
//   master : tick source / status consumer side (drives tick_i, reads status)
//   slave  : the monitor itself (reads tick_i, drives status)
//   Signals:
//     tick_i          one-cycle wrap pulse from the tick counter
//     led_o           LED drive, toggles on every accepted tick edge
//     period_o        last measured tick period in clock cycles
//     period_valid_o  one-cycle strobe when period_o updates
//     in_range_o      last period within the nominal tolerance window
//     timeout_o       level, no tick seen for the timeout interval
//     tick_cnt_o      number of valid periods measured (wraps)
// ----------------------------------------------------------------------------
interface blinker_tick_monitor_if #(
    parameter int unsigned CNT_W = 27
) ();

    logic             tick_i;
    logic             led_o;
    logic [CNT_W-1:0] period_o;
    logic             period_valid_o;
    logic             in_range_o;
    logic             timeout_o;
    logic [15:0]      tick_cnt_o;

    modport master (
        output tick_i,
        input  led_o,
        input  period_o,
        input  period_valid_o,
        input  in_range_o,
        input  timeout_o,
        input  tick_cnt_o
    );

    modport slave (
        input  tick_i,
        output led_o,
        output period_o,
        output period_valid_o,
        output in_range_o,
        output timeout_o,
        output tick_cnt_o
    );

endinterface

// File: rtl/blinker_tick_monitor.sv
// ----------------------------------------------------------------------------
// blinker_tick_monitor
//   Consumer end of the blinker tick path. Detects rising edges of the tick
//   pulse, toggles the LED on each one, measures the interval between edges,
//   flags periods outside EXPECTED +/- TOL and raises a timeout level when no
//   tick arrives for TIMEOUT cycles.
//   Ports:
//     system1000       clock, all logic on the rising edge
//     system1000_rstn  asynchronous reset, active low
//     bus              blinker_tick_monitor_if.slave (tick in, status out)
//   All status outputs are registered and update in the cycle after the edge.
// ----------------------------------------------------------------------------
module blinker_tick_monitor #(
    parameter int unsigned CNT_W    = 27,
    parameter int unsigned EXPECTED = 52428801,
    parameter int unsigned TOL      = 16,
    parameter int unsigned TIMEOUT  = 104857602
) (
    input  logic                   system1000,
    input  logic                   system1000_rstn,
    blinker_tick_monitor_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] EXP_C  = CNT_W'(EXPECTED);
    localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   TOL_C  = (CNT_W+1)'(TOL);
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MAX_C  = {CNT_W{1'b1}};

    state_t           state_r,        state_s;
    logic             tick_d_r;
    logic [CNT_W-1:0] cnt_r,          cnt_s;
    logic             led_r,          led_s;
    logic [CNT_W-1:0] period_r,       period_s;
    logic             period_valid_r, period_valid_s;
    logic             in_range_r,     in_range_s;
    logic             timeout_r,      timeout_s;
    logic [15:0]      tick_cnt_r,     tick_cnt_s;

    logic                    edge_s;
    logic signed [CNT_W:0]   diff_s;
    logic        [CNT_W:0]   mag_s;
    logic                    cnt_in_range_s;
    logic        [CNT_W-1:0] cnt_inc_s;

    // A tick held high for several cycles is accepted only once.
    assign edge_s = bus.tick_i & ~tick_d_r;

    // Tolerance check on one extra bit so the signed difference cannot wrap.
    always_comb begin
        diff_s = $signed({1'b0, cnt_r}) - $signed({1'b0, EXP_C});
        if (diff_s[CNT_W]) begin
            mag_s = $unsigned(-diff_s);
        end else begin
            mag_s = $unsigned(diff_s);
        end
        cnt_in_range_s = (mag_s <= TOL_C);
    end

    // Saturating increment of the period counter.
    always_comb begin
        if (cnt_r == MAX_C) begin
            cnt_inc_s = cnt_r;
        end else begin
            cnt_inc_s = cnt_r + ONE_C;
        end
    end

    // Next-state and next-output logic of the measurement FSM.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        led_s          = led_r;
        period_s       = period_r;
        period_valid_s = 1'b0;
        in_range_s     = in_range_r;
        timeout_s      = timeout_r;
        tick_cnt_s     = tick_cnt_r;

        case (state_r)
            ST_IDLE: begin
                if (edge_s) begin
                    state_s = ST_MEASURE;
                    cnt_s   = ONE_C;
                    led_s   = ~led_r;
                end else begin
                    cnt_s   = cnt_r;
                end
            end
            ST_MEASURE: begin
                // An edge coinciding with cnt == TIMEOUT is a valid period.
                if (edge_s) begin
                    cnt_s          = ONE_C;
                    led_s          = ~led_r;
                    period_s       = cnt_r;
                    period_valid_s = 1'b1;
                    in_range_s     = cnt_in_range_s;
                    tick_cnt_s     = tick_cnt_r + 16'd1;
                end else if (cnt_r == TMO_C) begin
                    state_s   = ST_TIMEOUT;
                    timeout_s = 1'b1;
                    cnt_s     = cnt_inc_s;
                end else begin
                    cnt_s     = cnt_inc_s;
                end
            end
            ST_TIMEOUT: begin
                // Partial period after a timeout is discarded.
                if (edge_s) begin
                    state_s   = ST_MEASURE;
                    cnt_s     = ONE_C;
                    led_s     = ~led_r;
                    timeout_s = 1'b0;
                end else begin
                    cnt_s     = cnt_r;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                cnt_s     = {CNT_W{1'b0}};
                timeout_s = 1'b0;
            end
        endcase
    end

    // State, edge-detect and output registers.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_r        <= ST_IDLE;
            tick_d_r       <= 1'b0;
            cnt_r          <= {CNT_W{1'b0}};
            led_r          <= 1'b0;
            period_r       <= {CNT_W{1'b0}};
            period_valid_r <= 1'b0;
            in_range_r     <= 1'b0;
            timeout_r      <= 1'b0;
            tick_cnt_r     <= 16'd0;
        end else begin
            state_r        <= state_s;
            tick_d_r       <= bus.tick_i;
            cnt_r          <= cnt_s;
            led_r          <= led_s;
            period_r       <= period_s;
            period_valid_r <= period_valid_s;
            in_range_r     <= in_range_s;
            timeout_r      <= timeout_s;
            tick_cnt_r     <= tick_cnt_s;
        end
    end

    assign bus.led_o          = led_r;
    assign bus.period_o       = period_r;
    assign bus.period_valid_o = period_valid_r;
    assign bus.in_range_o     = in_range_r;
    assign bus.timeout_o      = timeout_r;
    assign bus.tick_cnt_o     = tick_cnt_r;

endmodule

// File: tb/tb_blinker_tick_monitor.sv
// ----------------------------------------------------------------------------
// tb_blinker_tick_monitor
//   Directed and randomized tick sequences for blinker_tick_monitor with small
//   parameters. Expected outputs come from an elapsed-time model: the bench
//   remembers the cycle of the last accepted edge and derives period, range,
//   timeout and counts from plain arithmetic on cycle numbers.
// ----------------------------------------------------------------------------
module tb_blinker_tick_monitor;

    localparam int CNT_W    = 8;
    localparam int EXPECTED = 10;
    localparam int TOL      = 1;
    localparam int TIMEOUT  = 20;

    logic clk;
    logic rstn;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int now;
    int m_last;
    bit m_started;
    bit m_prev;
    bit m_led;
    int m_period;
    bit m_valid;
    bit m_in_range;
    bit m_timeout;
    int m_tick_cnt;

    blinker_tick_monitor_if #(.CNT_W(CNT_W)) bus ();

    blinker_tick_monitor #(
        .CNT_W    (CNT_W),
        .EXPECTED (EXPECTED),
        .TOL      (TOL),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .bus             (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s at cycle %0d: got %0d expected %0d", tag, now, got, exp);
        end
    endtask

    task automatic check_all();
        check("led",          int'(bus.led_o),          int'(m_led));
        check("period",       int'(bus.period_o),       m_period);
        check("period_valid", int'(bus.period_valid_o), int'(m_valid));
        check("in_range",     int'(bus.in_range_o),     int'(m_in_range));
        check("timeout",      int'(bus.timeout_o),      int'(m_timeout));
        check("tick_cnt",     int'(bus.tick_cnt_o),     m_tick_cnt);
    endtask

    task automatic model_reset();
        m_started  = 1'b0;
        m_prev     = 1'b0;
        m_led      = 1'b0;
        m_period   = 0;
        m_valid    = 1'b0;
        m_in_range = 1'b0;
        m_timeout  = 1'b0;
        m_tick_cnt = 0;
        m_last     = 0;
    endtask

    // One clock cycle with tick_i = t, then compare against the model.
    task automatic step(input bit t);
        bit edge_v;
        int d;
        bus.tick_i = t;
        @(posedge clk);
        #1;
        now++;
        edge_v = t && !m_prev;
        m_prev = t;
        m_valid = 1'b0;
        if (edge_v) begin
            m_led = !m_led;
            if (m_started && !m_timeout) begin
                m_period   = now - m_last;
                m_valid    = 1'b1;
                d          = m_period - EXPECTED;
                if (d < 0) d = -d;
                m_in_range = (d <= TOL);
                m_tick_cnt = (m_tick_cnt + 1) % 65536;
            end
            m_timeout = 1'b0;
            m_started = 1'b1;
            m_last    = now;
        end else if (m_started && !m_timeout && (now - m_last) == TIMEOUT) begin
            m_timeout = 1'b1;
        end
        check_all();
    endtask

    task automatic pulse(input int width, input int gap);
        for (int i = 0; i < width; i++) step(1'b1);
        for (int i = 0; i < gap; i++) step(1'b0);
    endtask

    // Assert reset mid-cycle, wiggle tick during it, release with tick low.
    task automatic apply_reset();
        rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < 3; i++) begin
            bus.tick_i = ~bus.tick_i;
            @(posedge clk);
            #1;
            now++;
            check_all();
        end
        bus.tick_i = 1'b0;
        rstn = 1'b1;
    endtask

    initial begin
        now = 0;
        model_reset();
        bus.tick_i = 1'b0;
        rstn = 1'b0;
        #2;
        apply_reset();

        // First tick after reset: LED toggles, no strobe, count stays 0
        pulse(1, 9);
        check("first_tick_cnt", int'(bus.tick_cnt_o), 0);

        // Steady ticks every 10 cycles: four more edges, four strobes
        for (int i = 0; i < 4; i++) pulse(1, 9);
        check("steady_tick_cnt", int'(bus.tick_cnt_o), 4);
        check("steady_period", int'(bus.period_o), 10);

        // Held pulse counts once; intervals 13 then 9
        pulse(3, 10);
        pulse(1, 8);
        pulse(1, 5);
        check("range_period9", int'(bus.period_o), 9);
        check("range_in9", int'(bus.in_range_o), 1);

        // Timeout after 25 idle cycles, recover, then a clean 10
        pulse(1, 25);
        check("timeout_level", int'(bus.timeout_o), 1);
        pulse(1, 9);
        pulse(1, 9);

        // Period exactly TIMEOUT is reported, no timeout
        pulse(1, 19);
        pulse(1, 19);
        check("boundary_no_timeout", int'(bus.timeout_o), 0);
        pulse(1, 9);

        // Mid-measurement reset at cnt = 6, then fresh start
        pulse(1, 5);
        apply_reset();
        pulse(1, 9);
        pulse(1, 9);

        // Randomized widths and gaps covering in/out of range and timeouts
        for (int n = 0; n < 60; n++) begin
            pulse(int'($urandom_range(1, 4)), int'($urandom_range(1, 24)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
